// File: rtl/gen_frame_tx.sv
// gen_frame_tx: framed serial transmitter.
// Each frame is a sync bit (S=1, I=1), DATA_BITS payload bits MSB first and
// an even-parity bit (optionally inverted), each held for BIT_CYCLES clocks.
// A new word may be accepted in the last cycle of the parity bit, so
// back-to-back frames leave no idle gap on the line.
module gen_frame_tx #(
  parameter int BIT_CYCLES = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  input  logic                 inject_err,
  output logic                 ready,
  output logic                 I,
  output logic                 S,
  output logic                 done
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 i_q, i_d;
  logic                 s_q, s_d;
  logic                 done_q, done_d;
  logic                 period_end;
  logic                 accept;

  // Handshake: ready in IDLE and in the final cycle of the parity bit.
  always_comb begin
    period_end = (cyc_q == CYC_LAST);
    ready      = (state_q == IDLE) || ((state_q == PARITY) && period_end);
    accept     = load && ready;
  end

  // Next-state, counter, shift register and output computation.
  always_comb begin
    state_d = state_q;
    cyc_d   = period_end ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    i_d     = i_q;
    s_d     = s_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        i_d   = 1'b0;
        s_d   = 1'b0;
      end
      SYNC: begin
        if (period_end) begin
          state_d = DATA;
          bit_d   = '0;
          s_d     = 1'b0;
          i_d     = shift_q[DATA_BITS-1];
          shift_d = shift_q << 1;
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = PARITY;
            i_d     = par_q;
          end else begin
            bit_d   = bit_q + 1'b1;
            i_d     = shift_q[DATA_BITS-1];
            shift_d = shift_q << 1;
          end
        end
      end
      PARITY: begin
        if (period_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
          i_d     = 1'b0;
          s_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        i_d     = 1'b0;
        s_d     = 1'b0;
      end
    endcase

    // Accept overrides the case above; it only happens in IDLE or at the
    // parity period end, so done_d from PARITY is kept for back-to-back frames.
    if (accept) begin
      state_d = SYNC;
      cyc_d   = '0;
      bit_d   = '0;
      shift_d = data_in;
      par_d   = (^data_in) ^ inject_err;
      i_d     = 1'b1;
      s_d     = 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      i_q     <= 1'b0;
      s_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      i_q     <= i_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  assign I    = i_q;
  assign S    = s_q;
  assign done = done_q;

endmodule

// File: tb/tb_gen_frame_tx.sv
// Testbench for gen_frame_tx: table-driven frames with a scoreboard-based
// per-cycle monitor, plus hand-written reset and small-parameter sequences.
module tb_gen_frame_tx;

  localparam int B  = 10;
  localparam int D  = 8;
  localparam int NP = D + 2;
  localparam int FL = NP * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       load = 1'b0;
  logic       inject_err = 1'b0;
  logic       ready, tx_i, tx_s, done;

  logic [0:0] d2 = '0;
  logic       l2 = 1'b0;
  logic       e2 = 1'b0;
  logic       r2, i2, s2, dn2;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  typedef struct {
    logic [9:0] bits;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic [9:0] bits;
    bit         hold;
    bit         poke;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  bit   active = 1'b0;
  logic prev_s = 1'b0;
  int   j = 0;
  int   done_due = -1;
  logic [9:0] got;
  vec_t vt[5];
  logic [3:0] sm_exp[14];

  gen_frame_tx #(.BIT_CYCLES(B), .DATA_BITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .inject_err(inject_err), .ready(ready), .I(tx_i), .S(tx_s), .done(done)
  );

  gen_frame_tx #(.BIT_CYCLES(2), .DATA_BITS(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .data_in(d2), .load(l2),
    .inject_err(e2), .ready(r2), .I(i2), .S(s2), .done(dn2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc_n);
    end
  endtask

  // Drive one word, push its expected frame when the accept edge has passed.
  task automatic send(input logic [7:0] d, input logic e, input logic [9:0] bits,
                      input bit hold, input bit poke);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready), 32'd1);
    data_in    = d;
    inject_err = e;
    load       = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{bits, cyc_n});
    data_in    = ~d;
    inject_err = ~e;
    if (!hold) load = 1'b0;
    if (poke) begin
      repeat (35) @(negedge clk);
      data_in = 8'h3C;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || active) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'({sb.size() == 0, !active}), 32'd3);
    repeat (3) @(negedge clk);
  endtask

  // Per-cycle monitor: idle outputs, frame contents, ready and done timing.
  initial begin : monitor
    logic [3:0] act;
    logic [3:0] expv;
    int         p;
    bit         exp_done;
    forever begin
      @(negedge clk);
      act      = {tx_i, tx_s, ready, done};
      exp_done = (cyc_n == done_due);
      if (!rst_n) begin
        active   = 1'b0;
        done_due = -1;
        chk("reset_outputs", 32'(act), 32'(4'b0010));
      end else begin
        if (!active && tx_s && !prev_s) begin
          if (sb.size() == 0) begin
            chk("spurious_frame", 32'(tx_s), 32'd0);
          end else begin
            cur      = sb.pop_front();
            active   = 1'b1;
            j        = 0;
            got      = '0;
            done_due = cur.acc + FL;
            chk("sync_latency", 32'(cyc_n), 32'(cur.acc));
          end
        end
        if (active) begin
          p    = j / B;
          expv = {cur.bits[NP-1-p], (p == 0), (j == FL - 1), exp_done};
          chk("frame_cycle", 32'(act), 32'(expv));
          if (j % B == B / 2) got[NP-1-p] = tx_i;
          if (j == FL - 1) begin
            active = 1'b0;
            chk("frame_bits", 32'(got), 32'(cur.bits));
          end
          j++;
        end else begin
          chk("idle_outputs", 32'(act), 32'({3'b001, exp_done}));
        end
      end
      prev_s = tx_s;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vt[0] = '{8'hA5, 1'b0, 10'b1101001010, 1'b0, 1'b1};
    vt[1] = '{8'h01, 1'b1, 10'b1000000010, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 1'b0, 10'b1111111110, 1'b1, 1'b0};
    vt[3] = '{8'h00, 1'b0, 10'b1000000000, 1'b0, 1'b0};
    vt[4] = '{8'h3C, 1'b1, 10'b1001111001, 1'b0, 1'b0};

    // {I,S,ready,done} for the small instance: data 1 then data 0.
    sm_exp = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b0011,
               4'b1100, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0011};

    #1;
    chk("reset_state_main", 32'({tx_i, tx_s, ready, done}), 32'(4'b0010));
    chk("reset_state_small", 32'({i2, s2, r2, dn2}), 32'(4'b0010));
    #11;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Minimal parameters: 3 bit periods of 2 clocks each.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk("small_ready", 32'(r2), 32'd1);
      d2 = (t == 0) ? 1'b1 : 1'b0;
      e2 = 1'b0;
      l2 = 1'b1;
      @(posedge clk);
      #1;
      l2 = 1'b0;
      d2 = ~d2;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        chk("small_frame", 32'({i2, s2, r2, dn2}), 32'(sm_exp[t*7+k]));
      end
    end

    // Table-driven frames on the main instance.
    for (int v = 0; v < 5; v++) begin
      send(vt[v].d, vt[v].e, vt[v].bits, vt[v].hold, vt[v].poke);
    end
    load = 1'b0;
    drain();

    // Reset during data bit 4 of a frame, then a clean frame straight after.
    send(8'hFF, 1'b0, 10'b1111111110, 1'b0, 1'b0);
    repeat (54) @(posedge clk);
    #2;
    chk("pre_reset_I", 32'(tx_i), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_async", 32'({tx_i, tx_s, ready, done}), 32'(4'b0010));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    data_in    = 8'h81;
    inject_err = 1'b0;
    load       = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{10'b1100000010, cyc_n});
    load    = 1'b0;
    data_in = 8'h00;
    chk("post_reset_accept", 32'({tx_i, tx_s}), 32'(2'b11));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
